// File: rtl/ps2_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse cursor controller.
package ps2_mouse_pkg;

    localparam int unsigned INC_W            = 9;
    localparam int unsigned RETRY_W          = 2;
    localparam int unsigned DEF_POS_W        = 11;
    localparam int unsigned DEF_X_MAX        = 639;
    localparam int unsigned DEF_Y_MAX        = 479;
    localparam int unsigned DEF_RESET_CYCLES = 64;
    localparam int unsigned DEF_MAX_RETRY    = 3;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_ACK    = 3'd2,
        ST_UPDATE = 3'd3,
        ST_RETRY  = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    // One movement packet as presented by ps2_mouse_interface.
    typedef struct packed {
        logic             left;
        logic             right;
        logic [INC_W-1:0] dx;
        logic [INC_W-1:0] dy;
    } ps2_pkt_t;

endpackage

// File: rtl/ps2_axis_clamp.sv
// Saturating add of a signed 9-bit increment to an unsigned coordinate,
// result clamped to [0, MAX]. INVERT=1 subtracts the increment instead.
// Ports:
//   value    in  POS_W  current coordinate (unsigned)
//   inc      in  INC_W  two's complement increment
//   result_c out POS_W  clamped new coordinate (combinational)
module ps2_axis_clamp
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned POS_W  = DEF_POS_W,
    parameter int unsigned MAX    = DEF_X_MAX,
    parameter bit          INVERT = 1'b0
) (
    input  logic [POS_W-1:0] value,
    input  logic [INC_W-1:0] inc,
    output logic [POS_W-1:0] result_c
);

    // Two guard bits: one for sign, one for overflow above 2^POS_W.
    localparam int unsigned SUM_W = POS_W + 2;

    logic signed [SUM_W-1:0] base_s;
    logic signed [SUM_W-1:0] inc_s;
    logic signed [SUM_W-1:0] sum;

    always_comb begin
        base_s = {2'b00, value};
        inc_s  = {{(SUM_W-INC_W){inc[INC_W-1]}}, inc};
        sum    = INVERT ? (base_s - inc_s) : (base_s + inc_s);
        if (sum[SUM_W-1]) begin
            result_c = '0;
        end else if (sum[SUM_W-2:0] > (SUM_W-1)'(MAX)) begin
            result_c = POS_W'(MAX);
        end else begin
            result_c = sum[POS_W-1:0];
        end
    end

endmodule

// File: rtl/ps2_mouse_cursor_ctrl.sv
// Sequencer for ps2_mouse_interface: holds the interface in reset after
// power-up, drains packets via data_ready/read, re-resets the interface on
// error_no_ack (bounded retries, then sticky fault), and integrates packet
// increments into a clamped screen cursor.
// Ports:
//   clk, reset (async active-low)
//   iface_reset  out  synchronous reset to the interface
//   data_ready / read   packet handshake (read is a one-cycle pulse)
//   left_button_i, right_button_i, x_increment, y_increment  packet payload
//   error_no_ack in   interface failed to get an ack from the mouse
//   recenter     in   move cursor to (X_MAX/2, Y_MAX/2)
//   pos_x, pos_y, left, right  cursor and buttons of last accepted packet
//   pos_valid    out  one-cycle strobe for a packet-driven update
//   fault        out  sticky, retries exhausted
//   retry_count  out  interface resets since last good packet
module ps2_mouse_cursor_ctrl
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned POS_W        = DEF_POS_W,
    parameter int unsigned X_MAX        = DEF_X_MAX,
    parameter int unsigned Y_MAX        = DEF_Y_MAX,
    parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int unsigned MAX_RETRY    = DEF_MAX_RETRY
) (
    input  logic               clk,
    input  logic               reset,
    output logic               iface_reset,
    input  logic               data_ready,
    output logic               read,
    input  logic               left_button_i,
    input  logic               right_button_i,
    input  logic [INC_W-1:0]   x_increment,
    input  logic [INC_W-1:0]   y_increment,
    input  logic               error_no_ack,
    input  logic               recenter,
    output logic [POS_W-1:0]   pos_x,
    output logic [POS_W-1:0]   pos_y,
    output logic               left,
    output logic               right,
    output logic               pos_valid,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_count
);

    localparam int unsigned CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [POS_W-1:0] X_CTR    = POS_W'(X_MAX / 2);
    localparam logic [POS_W-1:0] Y_CTR    = POS_W'(Y_MAX / 2);

    state_t               state, state_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    ps2_pkt_t             pkt_c;
    logic [POS_W-1:0]     nx_c, ny_c;

    logic                 iface_reset_d, read_d, pos_valid_d, fault_d;
    logic                 left_d, right_d;
    logic [POS_W-1:0]     pos_x_d, pos_y_d;
    logic [RETRY_W-1:0]   retry_count_d;

    assign pkt_c = {left_button_i, right_button_i, x_increment, y_increment};

    // X moves with dX; Y is screen-down so the upward dY is subtracted.
    ps2_axis_clamp #(.POS_W(POS_W), .MAX(X_MAX), .INVERT(1'b0)) u_clamp_x (
        .value    (pos_x),
        .inc      (pkt_c.dx),
        .result_c (nx_c)
    );

    ps2_axis_clamp #(.POS_W(POS_W), .MAX(Y_MAX), .INVERT(1'b1)) u_clamp_y (
        .value    (pos_y),
        .inc      (pkt_c.dy),
        .result_c (ny_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_INIT;
            cnt         <= '0;
            iface_reset <= 1'b1;
            read        <= 1'b0;
            pos_x       <= X_CTR;
            pos_y       <= Y_CTR;
            left        <= 1'b0;
            right       <= 1'b0;
            pos_valid   <= 1'b0;
            fault       <= 1'b0;
            retry_count <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            iface_reset <= iface_reset_d;
            read        <= read_d;
            pos_x       <= pos_x_d;
            pos_y       <= pos_y_d;
            left        <= left_d;
            right       <= right_d;
            pos_valid   <= pos_valid_d;
            fault       <= fault_d;
            retry_count <= retry_count_d;
        end
    end

    // Next state and next output values. The packet is folded into the
    // cursor on the edge leaving ACK, so pos_valid and the new position
    // appear together in the UPDATE cycle.
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        pos_x_d       = pos_x;
        pos_y_d       = pos_y;
        left_d        = left;
        right_d       = right;
        retry_count_d = retry_count;

        unique case (state)
            ST_INIT, ST_RETRY: begin
                if (cnt == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (error_no_ack) begin
                    if (retry_count < RETRY_W'(MAX_RETRY)) begin
                        state_d       = ST_RETRY;
                        cnt_d         = '0;
                        retry_count_d = retry_count + RETRY_W'(1);
                    end else begin
                        state_d = ST_FAULT;
                    end
                end else if (data_ready) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d       = ST_UPDATE;
                pos_x_d       = nx_c;
                pos_y_d       = ny_c;
                left_d        = pkt_c.left;
                right_d       = pkt_c.right;
                retry_count_d = '0;
            end
            ST_UPDATE: begin
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase

        // Recenter overrides any packet landing on the same edge.
        if (recenter && (state != ST_FAULT)) begin
            pos_x_d = X_CTR;
            pos_y_d = Y_CTR;
        end

        iface_reset_d = (state_d == ST_INIT) || (state_d == ST_RETRY) || (state_d == ST_FAULT);
        read_d        = (state_d == ST_ACK);
        pos_valid_d   = (state_d == ST_UPDATE);
        fault_d       = (state_d == ST_FAULT);
    end

endmodule

// File: tb/tb_ps2_mouse_cursor_ctrl.sv
// Self-checking bench for ps2_mouse_cursor_ctrl.
module tb_ps2_mouse_cursor_ctrl;

    localparam int X_MAX = 639;
    localparam int Y_MAX = 479;
    localparam int X_CTR = 319;
    localparam int Y_CTR = 239;
    localparam int RST_CYC = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        iface_reset;
    logic        data_ready = 1'b0;
    logic        read;
    logic        left_button_i = 1'b0;
    logic        right_button_i = 1'b0;
    logic [8:0]  x_increment = '0;
    logic [8:0]  y_increment = '0;
    logic        error_no_ack = 1'b0;
    logic        recenter = 1'b0;
    logic [10:0] pos_x, pos_y;
    logic        left, right, pos_valid, fault;
    logic [1:0]  retry_count;

    int checks = 0;
    int failures = 0;

    // Reference cursor state.
    int m_x, m_y, m_l, m_r;

    ps2_mouse_cursor_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .iface_reset    (iface_reset),
        .data_ready     (data_ready),
        .read           (read),
        .left_button_i  (left_button_i),
        .right_button_i (right_button_i),
        .x_increment    (x_increment),
        .y_increment    (y_increment),
        .error_no_ack   (error_no_ack),
        .recenter       (recenter),
        .pos_x          (pos_x),
        .pos_y          (pos_y),
        .left           (left),
        .right          (right),
        .pos_valid      (pos_valid),
        .fault          (fault),
        .retry_count    (retry_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dx;
        int dy;
        bit l;
        bit r;
        bit rc;
        bit hold;
        int ex;
        int ey;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int clampi(input int v, input int mx);
        if (v < 0) return 0;
        if (v > mx) return mx;
        return v;
    endfunction

    // Counts edges at which iface_reset is seen high, starting now.
    task automatic measure_reset(input string name);
        int n;
        n = 0;
        while (iface_reset === 1'b1 && n < 300) begin
            n++;
            tick();
        end
        check(name, n, RST_CYC);
    endtask

    // Issues one packet from IDLE and checks the handshake and the result.
    task automatic do_packet(input int dx, input int dy, input bit l, input bit r,
                             input bit rc, input bit hold, input string tag);
        data_ready     = 1'b1;
        x_increment    = 9'(dx);
        y_increment    = 9'(dy);
        left_button_i  = l;
        right_button_i = r;
        tick();
        check({tag, "_read"}, int'(read), 1);
        check({tag, "_early_valid"}, int'(pos_valid), 0);
        recenter   = rc;
        data_ready = hold;
        tick();
        recenter   = 1'b0;
        data_ready = 1'b0;
        if (rc) begin
            m_x = X_CTR;
            m_y = Y_CTR;
        end else begin
            m_x = clampi(m_x + dx, X_MAX);
            m_y = clampi(m_y - dy, Y_MAX);
        end
        m_l = l;
        m_r = r;
        check({tag, "_valid"}, int'(pos_valid), 1);
        check({tag, "_read_once"}, int'(read), 0);
        check({tag, "_x"}, int'(pos_x), m_x);
        check({tag, "_y"}, int'(pos_y), m_y);
        check({tag, "_lr"}, int'({left, right}), (m_l << 1) | m_r);
        check({tag, "_retry_clr"}, int'(retry_count), 0);
        tick();
        check({tag, "_valid_drop"}, int'(pos_valid), 0);
        check({tag, "_no_reread"}, int'(read), 0);
    endtask

    task automatic pulse_error(input string tag, input int exp_rc);
        error_no_ack = 1'b1;
        tick();
        error_no_ack = 1'b0;
        check({tag, "_rc"}, int'(retry_count), exp_rc);
        measure_reset({tag, "_len"});
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{dx:   5, dy:    3, l:1, r:0, rc:0, hold:1, ex: 324, ey: 236};
        vecs[1] = '{dx: 255, dy:  234, l:0, r:1, rc:0, hold:0, ex: 579, ey:   2};
        vecs[2] = '{dx:  56, dy:    0, l:1, r:1, rc:0, hold:0, ex: 635, ey:   2};
        vecs[3] = '{dx:  10, dy:   10, l:0, r:0, rc:0, hold:0, ex: 639, ey:   0};
        vecs[4] = '{dx:-256, dy: -256, l:1, r:0, rc:0, hold:0, ex: 383, ey: 256};
        vecs[5] = '{dx:-256, dy: -256, l:0, r:0, rc:0, hold:0, ex: 127, ey: 479};
        vecs[6] = '{dx: -27, dy:    0, l:0, r:1, rc:0, hold:0, ex: 100, ey: 479};
        vecs[7] = '{dx:-256, dy:    1, l:0, r:0, rc:0, hold:0, ex:   0, ey: 478};
        vecs[8] = '{dx:  50, dy:    0, l:1, r:0, rc:1, hold:0, ex: 319, ey: 239};

        // Reset values.
        #12;
        check("rst_iface_reset", int'(iface_reset), 1);
        check("rst_read", int'(read), 0);
        check("rst_pos_x", int'(pos_x), X_CTR);
        check("rst_pos_y", int'(pos_y), Y_CTR);
        check("rst_fault", int'(fault), 0);
        check("rst_valid", int'(pos_valid), 0);
        check("rst_retry", int'(retry_count), 0);
        tick();
        reset = 1'b1;
        m_x = X_CTR; m_y = Y_CTR; m_l = 0; m_r = 0;
        measure_reset("init_len");
        check("init_read", int'(read), 0);
        tick();
        check("init_done_iface", int'(iface_reset), 0);

        // Directed table: basic update, clamps, recenter on update edge.
        foreach (vecs[i]) begin
            do_packet(vecs[i].dx, vecs[i].dy, vecs[i].l, vecs[i].r,
                      vecs[i].rc, vecs[i].hold, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_tbl_x", i), int'(pos_x), vecs[i].ex);
            check($sformatf("vec%0d_tbl_y", i), int'(pos_y), vecs[i].ey);
        end

        // Two errors, then a good packet clears the retry count.
        pulse_error("err1", 1);
        pulse_error("err2", 2);
        do_packet(7, 0, 0, 1, 0, 0, "after_err");
        check("after_err_rc", int'(retry_count), 0);

        // Exhaust retries, then fault.
        pulse_error("errA", 1);
        pulse_error("errB", 2);
        pulse_error("errC", 3);
        error_no_ack = 1'b1;
        tick();
        error_no_ack = 1'b0;
        check("fault_set", int'(fault), 1);
        check("fault_iface", int'(iface_reset), 1);
        begin
            int reads, lows;
            reads = 0;
            lows  = 0;
            data_ready = 1'b1;
            recenter   = 1'b1;
            for (int k = 0; k < 12; k++) begin
                tick();
                if (read) reads++;
                if (!iface_reset || !fault) lows++;
            end
            data_ready = 1'b0;
            recenter   = 1'b0;
            check("fault_reads", reads, 0);
            check("fault_sticky", lows, 0);
            check("fault_pos_x", int'(pos_x), m_x);
            check("fault_pos_y", int'(pos_y), m_y);
        end

        // Leave fault via reset, then reset in the middle of ACK.
        reset = 1'b0;
        #1;
        check("fault_clear", int'(fault), 0);
        tick();
        reset = 1'b1;
        m_x = X_CTR; m_y = Y_CTR; m_l = 0; m_r = 0;
        measure_reset("reinit_len");
        check("reinit_rc", int'(retry_count), 0);
        data_ready  = 1'b1;
        x_increment = 9'd20;
        y_increment = 9'd0;
        tick();
        check("mid_ack_read", int'(read), 1);
        #2;
        reset = 1'b0;
        #1;
        data_ready = 1'b0;
        check("mid_ack_read_drop", int'(read), 0);
        check("mid_ack_iface", int'(iface_reset), 1);
        check("mid_ack_pos_x", int'(pos_x), X_CTR);
        check("mid_ack_valid", int'(pos_valid), 0);
        tick();
        reset = 1'b1;
        measure_reset("mid_ack_init_len");

        // Random packets and idle recenters against the model.
        for (int n = 0; n < 60; n++) begin
            int gap, dxr, dyr;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 9) == 0) begin
                    recenter = 1'b1;
                    tick();
                    recenter = 1'b0;
                    m_x = X_CTR;
                    m_y = Y_CTR;
                    check("rnd_recenter_x", int'(pos_x), m_x);
                    check("rnd_recenter_y", int'(pos_y), m_y);
                end else begin
                    tick();
                end
            end
            dxr = int'($urandom_range(0, 511));
            dyr = int'($urandom_range(0, 511));
            if (dxr >= 256) dxr -= 512;
            if (dyr >= 256) dyr -= 512;
            do_packet(dxr, dyr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                      $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
